trng_health: RTL and testbench
==============================

TRNG_HEALTH -- requirements
Module: trng_health

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit entropy words buffered (power of two, 2..16).
REQ-002 SHALL have parameter RCT_CUTOFF, default 4, number of consecutive identical words that triggers a repetition-count failure.
REQ-003 SHALL have parameter APT_LO, default 224, minimum ones-count per 16-word window.
REQ-004 SHALL have parameter APT_HI, default 288, maximum ones-count per 16-word window.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port src_valid, input, 1, raw entropy word available from the upstream source.
REQ-008 SHALL have port src_data, input, 32, raw entropy word.
REQ-009 SHALL have port src_ack, output, 1, raw word consumed this cycle.
REQ-010 SHALL have port cs, input, 1, API select.
REQ-011 SHALL have port we, input, 1, API write enable.
REQ-012 SHALL have port address, input, 8, API register address.
REQ-013 SHALL have port write_data, input, 32, API write data.
REQ-014 SHALL have port read_data, output, 32, API read data (combinational).
REQ-015 SHALL have port ready, output, 1, API ready; high in every cycle where cs is high.

Function
REQ-016 SHALL assert src_ack combinationally when src_valid=1, FIFO not full, and alarm=0; a word is accepted exactly in such cycles.
REQ-017 SHALL push an accepted word into the FIFO so it is readable from the cycle after acceptance.
REQ-018 SHALL run the RCT: run_ctr resets to 1 on a word differing from last_word, increments on an identical word, saturates at RCT_CUTOFF.
REQ-019 SHALL raise a failure when run_ctr would reach RCT_CUTOFF; the triggering word SHALL NOT be pushed.
REQ-020 SHALL run the APT: add popcount of each accepted word to ones_ctr (10 bits) and count words in win_ctr (4 bits, wraps 15->0).
REQ-021 SHALL evaluate ones_ctr, including the 16th word, at window end; outside [APT_LO, APT_HI] SHALL be a failure; both counters SHALL clear at window end regardless.
REQ-022 On a failure, SHALL set the sticky alarm, increment fail_ctr (16 bits, saturating at 0xffff), and flush the FIFO in the same cycle.
REQ-023 Register ADDR_CTRL 0x08, write: bit0=1 SHALL clear alarm, run_ctr, last_word, ones_ctr and win_ctr.
REQ-024 Register ADDR_STATUS 0x09, read: {29'h0, fifo_full, alarm, fifo_not_empty}.
REQ-025 Register ADDR_FAILS 0x0a, read: {16'h0, fail_ctr}.
REQ-026 Register ADDR_ENTROPY 0x20, read: SHALL return the FIFO head and pop it at the clock edge; an empty FIFO SHALL return 0 with no pop.
REQ-027 Any other address SHALL read 0, and writes to it SHALL have no effect.
REQ-028 Push and pop in the same cycle SHALL both occur, with the FIFO count unchanged, including when full.
REQ-029 A failure coinciding with a pop SHALL flush; the flush has priority.
REQ-030 An alarm clear coinciding with a failure SHALL leave alarm=1.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 With reset_n=0 at a clk edge, SHALL clear: FIFO (empty), alarm, fail_ctr, run_ctr, last_word, ones_ctr, win_ctr.
REQ-033 While in reset, src_ack SHALL be 0; read_data and ready SHALL follow cs and address only.

Configuration
REQ-034 With macro TRNG_HEALTH_APT_EN defined, SHALL implement the APT (REQ-020, REQ-021).
REQ-035 Without TRNG_HEALTH_APT_EN, SHALL omit the APT logic, so only the RCT can fail; register map unchanged.

Verification
REQ-036 Reset, then feed 4 distinct words with src_valid held -> 4 acks, status=0x5, fifo_full=1, the 5th word not acked; reading 0x20 four times returns the words in order, then status=0x0.
REQ-037 Feed 0xdeadbeef 4 times consecutively -> 3 words stored, the 4th triggers failure, FIFO flushed, status=0x2, fails=1, src_ack=0; write 0x08=1 -> status=0x0, acks resume.
REQ-038 (APT_EN) Feed 16 distinct words each with popcount 8 (ones=128) -> failure at the 16th word, fails=1; the same with popcount 16 words -> no failure.
REQ-039 Full FIFO with src_valid=1 and a read of 0x20 in the same cycle -> one pop and one push, status still full, order preserved.
REQ-040 Read 0x20 when empty -> read_data=0, ready=1, status unchanged; failure and alarm clear in the same cycle -> alarm remains 1.

Source files
------------

// File: rtl/trng_health.sv
// trng_health: entropy-source health monitor with a small word FIFO.
// Raw 32-bit words from the source are screened by a repetition-count test
// (RCT) and, when the macro TRNG_HEALTH_APT_EN is defined, by an adaptive
// proportion test (APT) over 16-word windows. Any failure latches a sticky
// alarm, bumps a saturating failure counter and flushes buffered words.
// Words that pass are readable one at a time through the register API.
module trng_health #(
   parameter int FIFO_DEPTH = 4,
   parameter int RCT_CUTOFF = 4,
   parameter int APT_LO     = 224,
   parameter int APT_HI     = 288
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        src_valid,
   input  logic [31:0] src_data,
   output logic        src_ack,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [RUN_W-1:0] CUTOFF_C = RUN_W'(RCT_CUTOFF);
   localparam logic [9:0]       APT_LO_C = 10'(APT_LO);
   localparam logic [9:0]       APT_HI_C = 10'(APT_HI);

   localparam logic [7:0] ADDR_CTRL    = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h09;
   localparam logic [7:0] ADDR_FAILS   = 8'h0a;
   localparam logic [7:0] ADDR_ENTROPY = 8'h20;

   // FIFO storage and bookkeeping
   logic [31:0]      fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // health state
   logic             alarm_r;
   logic [15:0]      fail_ctr_r;
   logic [31:0]      last_word_r;
   logic [RUN_W-1:0] run_ctr_r;

   // decoded control
   logic             fifo_full_s;
   logic             fifo_not_empty_s;
   logic             pop_s;
   logic             ctrl_clr_s;
   logic             src_ack_s;
   logic             push_s;
   logic             failure_s;
   logic [RUN_W-1:0] run_inc_s;
   logic             rct_fail_s;
   logic             apt_fail_s;
   logic [31:0]      read_data_s;
   logic             unused_s;

   assign fifo_full_s      = (count_r == DEPTH_C);
   assign fifo_not_empty_s = (count_r != {CNT_W{1'b0}});
   assign pop_s            = cs & ~we & (address == ADDR_ENTROPY) & fifo_not_empty_s;
   assign ctrl_clr_s       = cs & we & (address == ADDR_CTRL) & write_data[0];

   // a pop in the same cycle frees a slot, so a full FIFO can still accept
   assign src_ack_s = reset_n & src_valid & ~alarm_r & (~fifo_full_s | pop_s);
   assign failure_s = src_ack_s & (rct_fail_s | apt_fail_s);
   assign push_s    = src_ack_s & ~failure_s;

   assign src_ack   = src_ack_s;
   assign ready     = cs;
   assign read_data = read_data_s;
   assign unused_s  = ^{write_data[31:1], APT_LO_C, APT_HI_C};

   // RCT: next run length for the presented word and cutoff detection
   always_comb begin
      run_inc_s  = RUN_W'(1'b1);
      rct_fail_s = 1'b0;
      if (src_data == last_word_r) begin
         if (run_ctr_r >= CUTOFF_C) begin
            run_inc_s = CUTOFF_C;
         end else begin
            run_inc_s = run_ctr_r + RUN_W'(1'b1);
         end
      end else begin
         run_inc_s = RUN_W'(1'b1);
      end
      rct_fail_s = (run_inc_s == CUTOFF_C);
   end

`ifdef TRNG_HEALTH_APT_EN
   function automatic logic [5:0] popcount32(input logic [31:0] word);
      logic [5:0] acc;
      acc = 6'd0;
      for (int i = 0; i < 32; i++) begin
         acc = acc + {5'd0, word[i]};
      end
      return acc;
   endfunction

   logic [9:0] ones_ctr_r;
   logic [3:0] win_ctr_r;
   logic [9:0] ones_sum_s;
   logic       win_end_s;

   // APT: running ones total including the presented word, judged at window end
   always_comb begin
      ones_sum_s = ones_ctr_r + {4'd0, popcount32(src_data)};
      win_end_s  = (win_ctr_r == 4'd15);
      apt_fail_s = win_end_s & ((ones_sum_s < APT_LO_C) | (ones_sum_s > APT_HI_C));
   end

   // APT counters: accumulate per accepted word, restart every 16 words or on clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ones_ctr_r <= 10'd0;
         win_ctr_r  <= 4'd0;
      end else if (ctrl_clr_s) begin
         ones_ctr_r <= 10'd0;
         win_ctr_r  <= 4'd0;
      end else if (src_ack_s) begin
         if (win_end_s) begin
            ones_ctr_r <= 10'd0;
            win_ctr_r  <= 4'd0;
         end else begin
            ones_ctr_r <= ones_sum_s;
            win_ctr_r  <= win_ctr_r + 4'd1;
         end
      end
   end
`else
   assign apt_fail_s = 1'b0;
`endif

   // FIFO pointers and occupancy; a failure flush overrides push and pop
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (failure_s) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO data array write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= src_data;
      end
   end

   // sticky alarm and saturating failure count; a failure beats a clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         alarm_r    <= 1'b0;
         fail_ctr_r <= 16'h0000;
      end else if (failure_s) begin
         alarm_r <= 1'b1;
         if (fail_ctr_r != 16'hffff) begin
            fail_ctr_r <= fail_ctr_r + 16'h0001;
         end
      end else if (ctrl_clr_s) begin
         alarm_r <= 1'b0;
      end
   end

   // RCT state: remember the last accepted word and its run length
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_word_r <= 32'h0000_0000;
         run_ctr_r   <= {RUN_W{1'b0}};
      end else if (ctrl_clr_s) begin
         last_word_r <= 32'h0000_0000;
         run_ctr_r   <= {RUN_W{1'b0}};
      end else if (src_ack_s) begin
         last_word_r <= src_data;
         run_ctr_r   <= run_inc_s;
      end
   end

   // register read mux; unmapped addresses read as zero
   always_comb begin
      read_data_s = 32'h0000_0000;
      if (cs) begin
         case (address)
            ADDR_STATUS:  read_data_s = {29'h0, fifo_full_s, alarm_r, fifo_not_empty_s};
            ADDR_FAILS:   read_data_s = {16'h0, fail_ctr_r};
            ADDR_ENTROPY: read_data_s = fifo_not_empty_s ? fifo_mem_r[rd_ptr_r] : 32'h0000_0000;
            default:      read_data_s = 32'h0000_0000;
         endcase
      end else begin
         read_data_s = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_trng_health.sv
// Directed self-checking bench for trng_health (default parameters).
// Expected values are hand-derived; the APT scenario adapts to whether
// TRNG_HEALTH_APT_EN is defined for the build.
module tb_trng_health;

`ifdef TRNG_HEALTH_APT_EN
   localparam bit APT_ON = 1'b1;
`else
   localparam bit APT_ON = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ack;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   int vectors;
   int miscompares;

   trng_health dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_ack    (src_ack),
      .cs         (cs),
      .we         (we),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // read a register without consuming a clock edge
   task automatic peek(input logic [7:0] addr, input logic [31:0] exp, input string tag);
      cs = 1'b1; we = 1'b0; address = addr;
      #1;
      chk(tag, read_data, exp);
      cs = 1'b0;
   endtask

   // read the entropy port across one clock edge
   task automatic pop_chk(input logic [31:0] exp, input string tag);
      cs = 1'b1; we = 1'b0; address = 8'h20;
      #1;
      chk(tag, read_data, exp);
      chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
      tick();
      cs = 1'b0;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      cs = 1'b1; we = 1'b1; address = addr; write_data = data;
      tick();
      cs = 1'b0; we = 1'b0; write_data = 32'h0;
   endtask

   // present one word, expect it acknowledged, clock it in
   task automatic push(input logic [31:0] data, input string tag);
      src_valid = 1'b1; src_data = data;
      #1;
      chk(tag, {31'd0, src_ack}, 32'd1);
      tick();
      src_valid = 1'b0;
   endtask

   logic [31:0] words [5];
   logic [31:0] w;

   initial begin
      vectors = 0; miscompares = 0;
      reset_n = 1'b0; src_valid = 1'b1; src_data = 32'h0;
      cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'h0;
      tick(); tick();
      chk("ack_in_reset", {31'd0, src_ack}, 32'd0);
      chk("ready_idle", {31'd0, ready}, 32'd0);
      src_valid = 1'b0;
      reset_n = 1'b1;
      peek(8'h09, 32'h0, "rst_status");
      peek(8'h0a, 32'h0, "rst_fails");
      peek(8'h20, 32'h0, "rst_entropy");
      tick();

      // fill to full, fifth word refused, drain in order
      words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
      words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
      words[4] = 32'h5555_5555;
      for (int i = 0; i < 4; i++) push(words[i], "fill_ack");
      src_valid = 1'b1; src_data = words[4];
      #1;
      chk("full_no_ack", {31'd0, src_ack}, 32'd0);
      peek(8'h09, 32'h5, "full_status");
      tick();
      src_valid = 1'b0;
      for (int i = 0; i < 4; i++) pop_chk(words[i], "drain_order");
      peek(8'h09, 32'h0, "drained_status");

      // repetition count failure
      for (int i = 0; i < 4; i++) push(32'hdead_beef, "rct_ack");
      peek(8'h09, 32'h2, "rct_status");
      peek(8'h0a, 32'h1, "rct_fails");
      src_valid = 1'b1; src_data = 32'h1234_5678;
      #1;
      chk("alarm_no_ack", {31'd0, src_ack}, 32'd0);
      wr(8'h08, 32'h1);
      #1;
      chk("clr_ack_resume", {31'd0, src_ack}, 32'd1);
      peek(8'h09, 32'h0, "clr_status");
      tick();
      src_valid = 1'b0;
      pop_chk(32'h1234_5678, "post_clr_word");

      // simultaneous push and pop on a full FIFO
      words[0] = 32'ha000_0001; words[1] = 32'ha000_0002;
      words[2] = 32'ha000_0003; words[3] = 32'ha000_0004;
      words[4] = 32'ha000_0005;
      for (int i = 0; i < 4; i++) push(words[i], "fill2_ack");
      src_valid = 1'b1; src_data = words[4];
      cs = 1'b1; we = 1'b0; address = 8'h20;
      #1;
      chk("pushpop_ack", {31'd0, src_ack}, 32'd1);
      chk("pushpop_head", read_data, words[0]);
      tick();
      src_valid = 1'b0; cs = 1'b0;
      peek(8'h09, 32'h5, "pushpop_status");
      for (int i = 1; i < 5; i++) pop_chk(words[i], "pushpop_order");

      // empty read, unmapped address, write to a read-only register
      pop_chk(32'h0, "empty_read");
      peek(8'h09, 32'h0, "empty_status");
      peek(8'h33, 32'h0, "unmapped_read");
      wr(8'h09, 32'hffff_ffff);
      peek(8'h09, 32'h0, "ro_write_status");

      // failure and clear in the same cycle: alarm stays set
      push(words[4], "rep2_ack");
      push(words[4], "rep3_ack");
      src_valid = 1'b1; src_data = words[4];
      cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h1;
      #1;
      chk("racefail_ack", {31'd0, src_ack}, 32'd1);
      tick();
      src_valid = 1'b0; cs = 1'b0; we = 1'b0; write_data = 32'h0;
      peek(8'h09, 32'h2, "race_status");
      peek(8'h0a, 32'h2, "race_fails");
      wr(8'h08, 32'h0);
      peek(8'h09, 32'h2, "bit0_zero_status");
      wr(8'h08, 32'h1);
      peek(8'h09, 32'h0, "race_clr_status");

      // APT window of low-density words
      for (int i = 0; i < 16; i++) begin
         w = 32'h0000_00ff << i;
         push(w, "apt8_ack");
         pop_chk((APT_ON && i == 15) ? 32'h0 : w, "apt8_word");
      end
      peek(8'h09, APT_ON ? 32'h2 : 32'h0, "apt8_status");
      peek(8'h0a, APT_ON ? 32'h3 : 32'h2, "apt8_fails");
      wr(8'h08, 32'h1);

      // APT window of balanced words
      for (int i = 0; i < 16; i++) begin
         w = 32'h0000_ffff << i;
         push(w, "apt16_ack");
         pop_chk(w, "apt16_word");
      end
      peek(8'h09, 32'h0, "apt16_status");
      peek(8'h0a, APT_ON ? 32'h3 : 32'h2, "apt16_fails");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
